// File: rtl/mutex_merge_sync_sink.sv
// Clocked sink for the 9-way mutex merge: synchronizes the drive request,
// buffers its word in a FIFO, returns a stretched free pulse upstream.
module mutex_merge_sync_sink #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FREE_CYC    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_drive,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       o_free,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = $clog2(FREE_CYC+1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   pending;
  logic [FW-1:0]          free_cnt;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [CW-1:0]          count;
  logic                   err_q;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic det;
  logic busy;
  logic bad;
  logic want;
  logic full;
  logic wr;
  logic pop;

  assign det  = sync_q[SYNC_STAGES-1] & ~sync_prev;
  // A drive arriving while one is still unacknowledged is dropped.
  assign busy = pending | (free_cnt != '0);
  assign bad  = det & busy;
  assign want = (det & ~bad) | pending;
  assign full = (count == CW'(DEPTH));
  assign wr   = want & ~full;
  assign pop  = o_valid & i_ready;

  assign o_valid = (count != '0);
  assign o_data  = mem[rptr];
  assign o_count = count;
  assign o_free  = (free_cnt != '0);
  assign o_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      pending   <= 1'b0;
      free_cnt  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      err_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_drive};
      sync_prev <= sync_q[SYNC_STAGES-1];

      if (bad)
        err_q <= 1'b1;

      if (wr)
        pending <= 1'b0;
      else if (det & ~bad)
        pending <= 1'b1;

      if (wr)
        free_cnt <= FW'(FREE_CYC);
      else if (free_cnt != '0)
        free_cnt <= free_cnt - FW'(1);

      if (wr)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);

      unique case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= i_data;
  end

endmodule

// File: tb/tb_mutex_merge_sync_sink.sv
// Scoreboard bench for mutex_merge_sync_sink: queue model of accepted
// words and free pulses, randomized data and consumer backpressure.
module tb_mutex_merge_sync_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int FC    = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_drive;
  logic [DW-1:0] i_data;
  logic          o_free;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic          o_err;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] q[$];
  int            frees_exp = 0;
  int            frees_seen = 0;
  int            run = 0;
  bit            rand_rdy = 0;

  mutex_merge_sync_sink #(
    .DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS), .FREE_CYC(FC)
  ) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data),
    .o_free(o_free), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_count(o_count), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Monitor: pops the model queue on every consumer handshake and
  // measures each free pulse.
  always @(negedge clk) begin
    if (!rst) begin
      run = 0;
    end else begin
      if (o_valid && i_ready) begin
        if (q.size() == 0) chk("pop_unexpected", 1, 0);
        else chk("pop_data", o_data, q.pop_front());
      end
      if (o_free) begin
        run++;
      end else if (run != 0) begin
        chk("free_len", run, FC);
        frees_seen++;
        run = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] d, output int lat, output int cnt);
    i_data = d;
    i_drive = 1'b1;
    q.push_back(d);
    frees_exp++;
    lat = 0;
    while (!o_free && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    cnt = int'(o_count);
    chk("send_free", o_free, 1);
    i_drive = 1'b0;
    for (int i = 0; i < 20 && o_free; i++) begin
      @(posedge clk); #1;
    end
    tick(3);
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int i = 0; i < 60 && o_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", o_count, 0);
  endtask

  int lat, cnt;

  initial begin
    rst = 1'b0;
    i_drive = 1'b0;
    i_ready = 1'b0;
    i_data = '0;
    tick(3);
    chk("rst_free", o_free, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b1;
    tick(2);

    // single word
    i_ready = 1'b1;
    send(32'hA5A5_0001, lat, cnt);
    chk("single_lat", (lat >= SS && lat <= SS + 1) ? 1 : 0, 1);
    chk("single_count", cnt, 1);
    chk("single_empty", o_count, 0);

    // fill, then one pop releases the withheld fifth word
    i_ready = 1'b0;
    for (int d = 1; d <= 4; d++) send(DW'(d), lat, cnt);
    fork
      send(DW'(5), lat, cnt);
      begin
        tick(10);
        chk("fill_count", o_count, 4);
        chk("fill_free_held", o_free, 0);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        chk("pop_count", o_count, 3);
        chk("pop_free_held", o_free, 0);
        tick(1);
        chk("refill_free", o_free, 1);
        chk("refill_count", o_count, 4);
      end
    join
    drain();

    // wrap with ready held high
    for (int i = 0; i < 10; i++) send($urandom, lat, cnt);
    drain();
    chk("wrap_err", o_err, 0);

    // random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 12; i++) send($urandom, lat, cnt);
    rand_rdy = 0;
    drain();
    chk("rand_err", o_err, 0);

    // violation: second rise lands while free is still high
    i_ready = 1'b0;
    i_data = 32'hBEEF_0007;
    q.push_back(i_data);
    frees_exp++;
    i_drive = 1'b1;
    tick(1);
    i_drive = 1'b0;
    tick(1);
    i_drive = 1'b1;
    tick(6);
    i_drive = 1'b0;
    tick(6);
    chk("viol_err", o_err, 1);
    chk("viol_count", o_count, 1);
    chk("viol_frees", frees_seen, frees_exp);
    drain();

    // asynchronous reset mid-operation
    i_ready = 1'b0;
    send(32'h0000_1111, lat, cnt);
    send(32'h0000_2222, lat, cnt);
    i_data = 32'h0000_3333;
    q.push_back(i_data);
    i_drive = 1'b1;
    for (int i = 0; i < 50 && !o_free; i++) tick(1);
    chk("pre_rst_count", o_count, 3);
    chk("pre_rst_free", o_free, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_free", o_free, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_count", o_count, 0);
    chk("arst_err", o_err, 0);
    q.delete();
    i_drive = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);
    i_ready = 1'b1;
    send(32'h5, lat, cnt);
    drain();
    chk("post_rst_err", o_err, 0);

    tick(4);
    chk("frees_total", frees_seen, frees_exp);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mutex_merge_sync_sink.md
# mutex_merge_sync_sink

Clocked sink at the output of the 9-way mutex merge. It takes the merged drive request and its data word from the click-based micropipeline, synchronizes the request into the `clk` domain, and buffers the word in a small FIFO. It returns a stretched free pulse to the merge's `i_freeNext` input and presents the buffered words to synchronous logic through a valid/ready interface.

## Interface
Parameters:
- `DATA_W`, 32, width of the data word carried with each drive.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2, flops in the `i_drive` synchronizer; at least 2.
- `FREE_CYC`, 2, number of clk cycles `o_free` is held high per accepted word; at least 1.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous and active-low.
- `i_drive` input 1: asynchronous request (the merge's `o_driveNext`).
- `i_data` input DATA_W: word associated with the drive.
- `o_free` output 1: acknowledge to the merge's `i_freeNext`. Registered.
- `o_valid` output 1: FIFO not empty.
- `i_ready` input 1: consumer accepts `o_data`.
- `o_data` output DATA_W: FIFO head word.
- `o_count` output $clog2(DEPTH+1): current FIFO occupancy.
- `o_err` output 1: sticky protocol-violation flag.

## Operation
- Upstream contract:
  - `i_drive` rises once per word and stays high for at least SYNC_STAGES+1 clk periods.
  - `i_data` is stable from the `i_drive` rise until `o_free` has risen.
  - No new `i_drive` rise occurs before the `o_free` pulse for the previous word.
- Synchronizer: `i_drive` passes through a SYNC_STAGES flop chain. One further flop holds the previous synced value.
  - `det = sync_last & ~sync_prev` (rising edge detect).
- The `pending` flag is set by `det` and cleared when the word is written.
- Write: at the first edge where (`det` or `pending`) holds and `count < DEPTH`, write `i_data` at `wptr`.
  - The same edge loads the free counter with FREE_CYC and clears `pending`.
- Full: when `det` arrives and `count == DEPTH`, no write happens and `pending` is set.
  - The write happens on the first edge after `count` drops below DEPTH. `o_free` is withheld until then.
- `count` is registered. A pop in the same cycle does not make room for a write in that cycle: full blocks the write and it completes one cycle later.
- Read: `o_valid = (count != 0)`. `o_data` is the head word. On an edge with `o_valid & i_ready`, `rptr` advances.
- Simultaneous write and pop: `count` is unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `o_free` is high while the free counter is nonzero; the counter decrements each cycle.
- `o_err` is set, and stays set until reset, on:
  - `det` while `pending` is already set, or
  - `det` while the free counter is nonzero.
  - On either error the second drive is ignored: no write and no `o_free`.
- Reset (async, any time): synchronizer, `pending`, pointers, `count`, free counter and `o_err` all clear. Any in-flight word whose free was not yet issued is dropped; upstream must be reset together with this block.
- Reset values: `o_free`=0, `o_valid`=0, `o_count`=0, `o_err`=0. `o_data` is don't-care while `o_valid`=0.

## Timing
- Edge k is the first clk edge at which sync stage 1 samples `i_drive`=1.
- `det` is high during the cycle after edge k+SYNC_STAGES-1. With space available, the write happens at edge k+SYNC_STAGES.
- `o_free` is high from edge k+SYNC_STAGES through edge k+SYNC_STAGES+FREE_CYC.
- `o_valid` rises at edge k+SYNC_STAGES when the FIFO was empty.
- Drive-to-free latency is SYNC_STAGES clk cycles plus up to 1 cycle of sampling uncertainty.
- Pop-to-free latency when full: the pop occurs at edge p, the write and `o_free` rise at edge p+1.
- Throughput: at most one word per SYNC_STAGES+FREE_CYC+2 cycles, limited by the upstream handshake.

## Test plan
- Single word, defaults, `i_ready`=1: `i_drive`=1 with `i_data`=32'hA5A5_0001.
  - `o_free` high 2 cycles, starting 2–3 edges after the rise.
  - `o_valid` high 1 cycle with `o_data`=32'hA5A5_0001; `o_count` goes 0→1→0.
- Fill: `i_ready`=0, five sequential handshaked drives with data 1..5.
  - `o_count` reaches 4, the fifth `o_free` is withheld.
  - Raise `i_ready` for 1 cycle: pop 1; the next edge writes 5 and asserts `o_free`.
  - Drain order is 2,3,4,5.
- Wrap: 10 words with `i_ready`=1 throughout; output order equals input order across pointer wrap, and `o_err` stays 0.
- Violation: a second `i_drive` rise arrives while `o_free` is still high. `o_err` becomes 1, no extra FIFO entry is written, and no extra `o_free` is issued.
- Reset mid-operation: `rst`=0 asserted with `o_count`=3 and `o_free` high. All outputs go to 0 immediately, without waiting for a clk edge. After release, a new drive with 32'h5 is accepted normally.
